// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, ASCII codes, status word layout.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    UTS_IDLE = 2'd0,
    UTS_SEND = 2'd1,
    UTS_WAIT = 2'd2
  } uts_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef struct packed {
    logic [19:0] rsvd;
    logic        busy;
    logic        ovf;
    logic        full;
    logic        empty;
    logic [7:0]  level;
  } uts_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; push/pop take effect on the next edge.
// Push while full and pop while empty are ignored; DEPTH must be a power of two.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Queues CPU byte stores and strobes one byte to the uart every BYTE_CYCLES; wr_en->uart_wr is 2 cycles when idle.
// No backpressure: stores to a full queue are dropped and flagged in ovf. Define UART_TX_CRLF_EN to expand LF into CR,LF.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int BYTE_CYCLES = 8680
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  output logic        uart_wr,
  output logic [7:0]  uart_dat,
  output logic [31:0] status
);

  localparam int             FCW       = $clog2(DEPTH + 1);
  localparam int             TW        = $clog2(BYTE_CYCLES);
  localparam logic [TW-1:0]  WAIT_LOAD = TW'(BYTE_CYCLES - 2);

  uts_state_t     state;
  logic [TW-1:0]  cnt;
  logic           ovf;
  logic [7:0]     head;
  logic           full;
  logic           empty;
  logic [FCW-1:0] count;
  logic           launch;
  logic           emit_cr;
  logic           pop;
  uts_status_t    st;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .NRST  (NRST),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Launching straight out of the last WAIT cycle keeps pulses exactly BYTE_CYCLES apart.
  assign launch = ~empty & ((state == UTS_IDLE) | ((state == UTS_WAIT) & (cnt == '0)));
  assign pop    = launch & ~emit_cr;

`ifdef UART_TX_CRLF_EN
  logic cr_sent;

  assign emit_cr = (head == ASCII_LF) & ~cr_sent;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)       cr_sent <= 1'b0;
    else if (launch) cr_sent <= emit_cr;
  end
`else
  assign emit_cr = 1'b0;
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state    <= UTS_IDLE;
      cnt      <= '0;
      uart_wr  <= 1'b0;
      uart_dat <= 8'h00;
    end else begin
      uart_wr <= 1'b0;
      if (launch) begin
        state    <= UTS_SEND;
        uart_wr  <= 1'b1;
        uart_dat <= emit_cr ? ASCII_CR : head;
      end else begin
        case (state)
          UTS_SEND: begin
            state <= UTS_WAIT;
            cnt   <= WAIT_LOAD;
          end
          UTS_WAIT: begin
            if (cnt == '0) state <= UTS_IDLE;
            else           cnt   <= cnt - TW'(1);
          end
          default: state <= UTS_IDLE;
        endcase
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)              ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
    else if (clr_ovf)       ovf <= 1'b0;
  end

  always_comb begin
    st       = '0;
    st.busy  = (state != UTS_IDLE);
    st.ovf   = ovf;
    st.full  = full;
    st.empty = empty;
    st.level = 8'(count);
  end

  assign status = st;

endmodule
